// File: rtl/rr_arb4.sv
// rr_arb4 - four-requester round-robin arbiter for a single-owner resource.
//
// The owner keeps the grant until it drops its request. If it holds the
// grant for HOLD_MAX consecutive cycles while another requester waits, the
// grant is rotated to the next requester in round-robin order. A HOLD_MAX
// of 0 disables this rotation.
//
// Ports:
//   clk     - system clock, all state updates on the rising edge
//   rst_n   - asynchronous active-low reset
//   req     - request vector, bit i high: requester i wants/holds the resource
//   gnt     - registered one-hot grant, all-zero when nobody owns the resource
//   gnt_id  - registered binary index of the owner, 0 when gnt is 0
//   gnt_vld - registered, high when any gnt bit is high
//
// req is only sampled at clock edges; every output comes straight from a
// flop, so there is no combinational path from req to any output.

module rr_arb4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_vld
);

  localparam int unsigned HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state, state_d;
  logic [1:0]      last, last_d;
  logic [HW-1:0]   hold_cnt, hold_d;
  logic [3:0]      gnt_d;
  logic [1:0]      id_d;
  logic            vld_d;
  logic [3:0]      others;
  logic [2:0]      pick;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Returns {found, index}: first set bit of cand searching from (from+1)
  // upward with wrap-around, so 'from' itself is examined last.
  function automatic logic [2:0] rr_pick(input logic [3:0] cand,
                                         input logic [1:0] from);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = from + 2'(k);
      if (!res[2] && cand[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  always_comb begin
    state_d = state;
    last_d  = last;
    hold_d  = hold_cnt;
    others  = req & ~onehot(last);
    pick    = '0;

    case (state)
      IDLE: begin
        pick = rr_pick(req, last);
        if (pick[2]) begin
          state_d = GRANT;
          last_d  = pick[1:0];
          hold_d  = HOLD_ONE;
        end
      end

      GRANT: begin
        // Release and preemption both choose among the non-owners; searching
        // from the owner's index already yields round-robin order for them.
        pick = rr_pick(others, last);
        if (!req[last]) begin
          if (pick[2]) begin
            last_d = pick[1:0];
            hold_d = HOLD_ONE;
          end else begin
            state_d = IDLE;
            hold_d  = '0;
          end
        end else if (HOLD_MAX != 0 && hold_cnt == HOLD_LIM && pick[2]) begin
          last_d = pick[1:0];
          hold_d = HOLD_ONE;
        end else if (HOLD_MAX != 0 && hold_cnt != HOLD_LIM) begin
          hold_d = hold_cnt + HOLD_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase

    // Outputs are derived from the next state so gnt, gnt_id and gnt_vld
    // are always registered together and mutually consistent.
    if (state_d == GRANT) begin
      gnt_d = onehot(last_d);
      id_d  = last_d;
      vld_d = 1'b1;
    end else begin
      gnt_d = '0;
      id_d  = '0;
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 2'd3;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
      gnt_vld  <= 1'b0;
    end else begin
      state    <= state_d;
      last     <= last_d;
      hold_cnt <= hold_d;
      gnt      <= gnt_d;
      gnt_id   <= id_d;
      gnt_vld  <= vld_d;
    end
  end

endmodule

// File: tb/tb_rr_arb4.sv
module tb_rr_arb4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_vld;
  logic [3:0] req2;
  logic [3:0] gnt2;
  logic [1:0] gnt_id2;
  logic       gnt_vld2;

  int vecs;
  int errs;

  rr_arb4 #(.HOLD_MAX(8)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  rr_arb4 #(.HOLD_MAX(2)) u_dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req2),
    .gnt     (gnt2),
    .gnt_id  (gnt_id2),
    .gnt_vld (gnt_vld2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_g;
    logic [1:0] exp_i;
    vecs  = 0;
    errs  = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    req2  = 4'b0000;

    // reset state
    #12;
    check("rst_gnt", {4'b0, gnt}, 8'h00);
    check("rst_id",  {6'b0, gnt_id}, 8'h00);
    check("rst_vld", {7'b0, gnt_vld}, 8'h00);
    rst_n = 1'b1;

    // single request, one-cycle latency
    req = 4'b0100;
    step();
    check("single_gnt", {4'b0, gnt}, 8'h04);
    check("single_id",  {6'b0, gnt_id}, 8'h02);
    check("single_vld", {7'b0, gnt_vld}, 8'h01);
    req = 4'b0000;
    step();
    check("drop_gnt", {4'b0, gnt}, 8'h00);
    check("drop_vld", {7'b0, gnt_vld}, 8'h00);

    // fresh reset so priority restarts at requester 0
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;

    // fairness: each requester owns the grant for 8 cycles
    req = 4'b1111;
    for (int c = 1; c <= 40; c++) begin
      step();
      exp_i = 2'(((c - 1) / 8) % 4);
      exp_g = 4'b0001 << exp_i;
      check("fair_gnt", {4'b0, gnt}, {4'b0, exp_g});
      check("fair_id",  {6'b0, gnt_id}, {6'b0, exp_i});
    end

    // owner 0 releases, 1 takes over; then 1 releases straight to 3
    req = 4'b0010;
    step();
    check("hand_a", {4'b0, gnt}, 8'h02);
    req = 4'b1010;
    step();
    check("hand_hold", {4'b0, gnt}, 8'h02);
    req = 4'b1000;
    step();
    check("hand_gnt", {4'b0, gnt}, 8'h08);
    check("hand_vld", {7'b0, gnt_vld}, 8'h01);

    // wrap-around priority from last=3
    req = 4'b0000;
    step();
    check("wrap_idle", {4'b0, gnt}, 8'h00);
    req = 4'b1001;
    step();
    check("wrap_0", {4'b0, gnt}, 8'h01);
    req = 4'b1000;
    step();
    check("wrap_3", {4'b0, gnt}, 8'h08);
    req = 4'b0001;
    step();
    check("wrap_0b", {4'b0, gnt}, 8'h01);
    check("wrap_0b_id", {6'b0, gnt_id}, 8'h00);

    // release while two new requests rise: round-robin picks 1
    req = 4'b0110;
    step();
    check("simul_gnt", {4'b0, gnt}, 8'h02);
    req = 4'b0100;
    step();
    check("pre_rst_gnt", {4'b0, gnt}, 8'h04);

    // async reset mid-grant
    #2 rst_n = 1'b0;
    #1;
    check("async_gnt", {4'b0, gnt}, 8'h00);
    check("async_id",  {6'b0, gnt_id}, 8'h00);
    check("async_vld", {7'b0, gnt_vld}, 8'h00);
    req = 4'b1100;
    #2 rst_n = 1'b1;
    step();
    check("post_rst_gnt", {4'b0, gnt}, 8'h04);
    check("post_rst_id",  {6'b0, gnt_id}, 8'h02);
    req = 4'b0000;

    // HOLD_MAX=2, no contention: grant never rotates or drops
    req2 = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      step();
      check("sat_gnt", {4'b0, gnt2}, 8'h02);
    end

    // contention after saturation: preempt to 0, hold 2 cycles, back to 1
    req2 = 4'b0011;
    step();
    check("pre_a", {4'b0, gnt2}, 8'h01);
    step();
    check("pre_b", {4'b0, gnt2}, 8'h01);
    step();
    check("pre_c", {4'b0, gnt2}, 8'h02);
    check("pre_c_id", {6'b0, gnt_id2}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
